pmp_csr_regfile: RTL and testbench

- Write side of the PMP configuration path: architectural register file for pmpcfg0/pmpcfg2 and pmpaddr0..15 on RV64.
- Receives CSR accesses over a valid/ready request/response handshake and enforces lock and WARL rules.
- Drives the packed conf_i / conf_addr_i vectors consumed by every PMP checker instance in the MMU/LSU.
- Optionally pulses a flush to invalidate cached permission results.

---
 rtl/pmp_csr_regfile_if.sv | 22 ++
 rtl/pmp_csr_regfile.sv | 126 ++++++++++++
 tb/tb_pmp_csr_regfile.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pmp_csr_regfile_if.sv
// rtl/pmp_csr_regfile_if.sv - CSR request/response handshake between the CSR unit and the PMP register file.
interface pmp_csr_regfile_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [11:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [63:0] rsp_rdata_o;
   logic        rsp_error_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
   );
endinterface

// File: rtl/pmp_csr_regfile.sv
// rtl/pmp_csr_regfile.sv - RV64 pmpcfg0/2 and pmpaddr0..15 register file with lock/WARL rules.
// Optional change flush pulse is built when PMP_CHANGE_FLUSH_EN is defined.
module pmp_csr_regfile #(
   parameter int PMP_LEN    = 54,
   parameter int NR_ENTRIES = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   pmp_csr_regfile_if.slave          bus,
   output logic [15:0][7:0]          conf_o,
   output logic [15:0][PMP_LEN-1:0]  conf_addr_o,
   output logic                      flush_o
);
   typedef enum logic {IDLE, RESP} state_e;

   state_e                   state_q, state_d;
   logic [15:0][7:0]         cfg_q, cfg_d;
   logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
   logic [63:0]              rdata_q, rdata_d;
   logic                     err_q, err_d;

   logic       is_cfg, is_addr;
   logic [3:0] cfg_base, aidx;
   logic [7:0] nb;
   logic       tor_lock;

   always_comb begin
      state_d  = state_q;
      cfg_d    = cfg_q;
      addr_d   = addr_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      nb       = 8'h00;
      tor_lock = 1'b0;
      is_cfg   = (bus.req_addr_i == 12'h3A0) || (bus.req_addr_i == 12'h3A2);
      is_addr  = (bus.req_addr_i[11:4] == 8'h3B);
      cfg_base = bus.req_addr_i[1] ? 4'd8 : 4'd0;
      aidx     = bus.req_addr_i[3:0];

      case (state_q)
         IDLE: begin
            if (bus.req_valid_i) begin
               state_d = RESP;
               err_d   = !(is_cfg || is_addr);
               rdata_d = 64'h0;
               if (is_cfg) begin
                  for (int j = 0; j < 8; j++) begin
                     rdata_d[8*j +: 8] = cfg_q[cfg_base + 4'(j)];
                  end
               end else if (is_addr) begin
                  rdata_d = 64'(addr_q[aidx]);
               end

               // Every lock test looks at cfg_q, so a write setting L still lands.
               if (bus.req_we_i && is_cfg) begin
                  for (int j = 0; j < 8; j++) begin
                     nb = bus.req_wdata_i[8*j +: 8];
                     if ((int'(cfg_base) + j < NR_ENTRIES) && !cfg_q[cfg_base + 4'(j)][7]
                         && !(nb[1] && !nb[0])) begin
                        cfg_d[cfg_base + 4'(j)] = nb & 8'h9F;
                     end
                  end
               end

               if (bus.req_we_i && is_addr) begin
                  if (aidx != 4'd15) begin
                     tor_lock = cfg_q[aidx + 4'd1][7] && (cfg_q[aidx + 4'd1][4:3] == 2'b01);
                  end
                  if ((int'(aidx) < NR_ENTRIES) && !cfg_q[aidx][7] && !tor_lock) begin
                     addr_d[aidx] = bus.req_wdata_i[PMP_LEN-1:0];
                  end
               end
            end
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         addr_q  <= '0;
         rdata_q <= 64'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready_o = (state_q == IDLE);
   assign bus.rsp_valid_o = (state_q == RESP);
   assign bus.rsp_rdata_o = rdata_q;
   assign bus.rsp_error_o = err_q;
   assign conf_o          = cfg_q;
   assign conf_addr_o     = addr_q;

`ifdef PMP_CHANGE_FLUSH_EN
   logic flush_q, flush_d;

   // Only the accepting edge can change state, so the pulse lands on the first RESP cycle.
   always_comb begin
      flush_d = (state_q == IDLE) && ((cfg_d != cfg_q) || (addr_d != addr_q));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         flush_q <= 1'b0;
      end else begin
         flush_q <= flush_d;
      end
   end

   assign flush_o = flush_q;
`else
   assign flush_o = 1'b0;
`endif
endmodule

// File: tb/tb_pmp_csr_regfile.sv
// tb/tb_pmp_csr_regfile.sv - Directed table-driven bench for pmp_csr_regfile.
module tb_pmp_csr_regfile;
`ifdef PMP_CHANGE_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      logic        err;
      logic        chg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0][7:0]  conf;
   logic [15:0][53:0] conf_addr;
   logic              flush;
   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   pmp_csr_regfile_if bus();

   pmp_csr_regfile dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus.slave),
      .conf_o      (conf),
      .conf_addr_o (conf_addr),
      .flush_o     (flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [11:0] a, input logic [63:0] d,
                      input logic [63:0] rd, input logic er, input logic chg);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.rdata = rd; v.err = er; v.chg = chg;
      vecs.push_back(v);
   endtask

   task automatic access(input logic we, input logic [11:0] a, input logic [63:0] d,
                         output logic rv, output logic [63:0] rd, output logic er,
                         output logic fl);
      int n = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = a;
      bus.req_wdata_i = d;
      bus.rsp_ready_i = 1'b0;
      while (!bus.req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("accept_timeout", 64'(bus.req_ready_o), 64'h1);
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      rv = bus.rsp_valid_o;
      rd = bus.rsp_rdata_o;
      er = bus.rsp_error_o;
      fl = flush;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready_i = 1'b0;
   endtask

   initial begin
      logic        rv, er, fl;
      logic [63:0] rd;

      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_addr_i  = 12'h0;
      bus.req_wdata_i = 64'h0;
      bus.rsp_ready_i = 1'b0;

      // Expected rdata on writes is the pre-write value.
      add(0, 12'h3A0, 64'h0,                 64'h0,                 0, 0);
      add(1, 12'h3B0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,               0, 1);
      add(0, 12'h3B0, 64'h0,                 64'h003F_FFFF_FFFF_FFFF, 0, 0);
      add(1, 12'h3A0, 64'h8F0F,              64'h0,                 0, 1);
      // entry1 is now locked TOR, so pmpaddr0 is frozen
      add(1, 12'h3B0, 64'h1234,              64'h003F_FFFF_FFFF_FFFF, 0, 0);
      add(0, 12'h3B0, 64'h0,                 64'h003F_FFFF_FFFF_FFFF, 0, 0);
      add(1, 12'h3A0, 64'h0,                 64'h8F0F,              0, 1);
      add(0, 12'h3A0, 64'h0,                 64'h8F00,              0, 0);
      add(1, 12'h3B1, 64'h55,                64'h0,                 0, 0);
      add(1, 12'h3A0, 64'h0001_0000,         64'h8F00,              0, 1);
      add(1, 12'h3A0, 64'h0002_0000,         64'h0001_8F00,         0, 0);
      add(0, 12'h3A0, 64'h0,                 64'h0001_8F00,         0, 0);
      add(0, 12'h3A1, 64'h0,                 64'h0,                 1, 0);
      add(1, 12'h3A1, 64'hFF,                64'h0,                 1, 0);
      add(1, 12'h3A0, 64'h0001_8F60,         64'h0001_8F00,         0, 0);
      add(1, 12'h3A0, 64'h0001_8F7D,         64'h0001_8F00,         0, 1);
      add(0, 12'h3A0, 64'h0,                 64'h0001_8F1D,         0, 0);
      add(1, 12'h3B2, 64'hABCD,              64'h0,                 0, 1);
      add(0, 12'h3B2, 64'h0,                 64'hABCD,              0, 0);
      add(1, 12'h3A2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,               0, 1);
      add(0, 12'h3A2, 64'h0,                 64'h9F9F_9F9F_9F9F_9F9F, 0, 0);
      add(1, 12'h3BF, 64'h1,                 64'h0,                 0, 0);
      add(0, 12'h3BF, 64'h0,                 64'h0,                 0, 0);
      add(1, 12'h3A2, 64'h0,                 64'h9F9F_9F9F_9F9F_9F9F, 0, 0);
      add(1, 12'h3B7, 64'h77,                64'h0,                 0, 1);
      add(0, 12'h3B7, 64'h0,                 64'h77,                0, 0);
      add(0, 12'hC00, 64'h0,                 64'h0,                 1, 0);

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready_o), 64'h1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rdata", bus.rsp_rdata_o, 64'h0);
      chk("rst_error", 64'(bus.rsp_error_o), 64'h0);
      chk("rst_flush", 64'(flush), 64'h0);
      chk("rst_conf_zero", 64'(conf == '0), 64'h1);
      chk("rst_addr_zero", 64'(conf_addr == '0), 64'h1);

      for (int i = 0; i < vecs.size(); i++) begin
         access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rv, rd, er, fl);
         chk($sformatf("v%0d_rsp_valid", i), 64'(rv), 64'h1);
         chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
         chk($sformatf("v%0d_error", i), 64'(er), 64'(vecs[i].err));
         chk($sformatf("v%0d_flush", i), 64'(fl), 64'(FLUSH_EN && vecs[i].chg));
      end

      chk("conf0", 64'(conf[0]), 64'h1D);
      chk("conf1", 64'(conf[1]), 64'h8F);
      chk("conf2", 64'(conf[2]), 64'h01);
      chk("conf8", 64'(conf[8]), 64'h9F);
      chk("conf15", 64'(conf[15]), 64'h9F);
      chk("addr0", 64'(conf_addr[0]), 64'h003F_FFFF_FFFF_FFFF);
      chk("addr1", 64'(conf_addr[1]), 64'h0);
      chk("addr2", 64'(conf_addr[2]), 64'hABCD);
      chk("addr7", 64'(conf_addr[7]), 64'h77);
      chk("addr15", 64'(conf_addr[15]), 64'h0);

      // Stalled response with a waiting request, then reset during RESP.
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_addr_i  = 12'h3B3;
      bus.req_wdata_i = 64'h33;
      bus.rsp_ready_i = 1'b0;
      @(posedge clk);
      #1;
      chk("stall_conf_addr3", 64'(conf_addr[3]), 64'h33);
      chk("stall_flush", 64'(flush), 64'(FLUSH_EN));
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall%0d_req_ready", k), 64'(bus.req_ready_o), 64'h0);
         chk($sformatf("stall%0d_rsp_valid", k), 64'(bus.rsp_valid_o), 64'h1);
         chk($sformatf("stall%0d_rdata", k), bus.rsp_rdata_o, 64'h0);
         chk($sformatf("stall%0d_error", k), 64'(bus.rsp_error_o), 64'h0);
         @(posedge clk);
         #1;
      end
      chk("stall_flush_single", 64'(flush), 64'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(bus.rsp_valid_o), 64'h0);
      chk("midrst_req_ready", 64'(bus.req_ready_o), 64'h1);
      chk("midrst_conf_zero", 64'(conf == '0), 64'h1);
      chk("midrst_addr_zero", 64'(conf_addr == '0), 64'h1);
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      access(0, 12'h3B3, 64'h0, rv, rd, er, fl);
      chk("post_rst_addr3", rd, 64'h0);
      access(0, 12'h3A0, 64'h0, rv, rd, er, fl);
      chk("post_rst_cfg0", rd, 64'h0);
      access(1, 12'h3B0, 64'h99, rv, rd, er, fl);
      access(0, 12'h3B0, 64'h0, rv, rd, er, fl);
      chk("post_rst_unlocked", rd, 64'h99);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
